// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory request/response bus between the LSU (master) and the memory responder (slave)
// Signals: memReqValid_out/memReqReady_in request handshake, memWe_out write enable,
//          memAddr_out word-aligned address, memWData_out/memWStrb_out store data and byte strobes,
//          memRspValid_in/memRspData_in response handshake and read word.
// Suffixes are named from the LSU's point of view.
interface load_store_unit_if #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH = 64
);
    localparam int XLEN = 1 << REG_DATA_WIDTH_POW;
    localparam int NBYTES = XLEN / 8;
    logic memReqValid_out;
    logic memReqReady_in;
    logic memWe_out;
    logic [ADDR_WIDTH-1:0] memAddr_out;
    logic [XLEN-1:0] memWData_out;
    logic [NBYTES-1:0] memWStrb_out;
    logic memRspValid_in;
    logic [XLEN-1:0] memRspData_in;
    modport master (
        output memReqValid_out, memWe_out, memAddr_out, memWData_out, memWStrb_out,
        input memReqReady_in, memRspValid_in, memRspData_in
    );
    modport slave (
        input memReqValid_out, memWe_out, memAddr_out, memWData_out, memWStrb_out,
        output memReqReady_in, memRspValid_in, memRspData_in
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface (align/mask stores, extract/extend loads)
// Ports: clk_in, reset (async, active high); core side start_in, isStore_in, funct3_in, addr_in,
//        storeData_in, busy_out, done_out, fault_out, loadData_out; memory side via load_store_unit_if.master.
// Option: define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses; otherwise the offset is
//         rounded down to natural alignment and the access proceeds.
module load_store_unit #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH = 64,
    localparam int XLEN = 1 << REG_DATA_WIDTH_POW,
    localparam int NBYTES = XLEN / 8,
    localparam int OFFW = REG_DATA_WIDTH_POW - 3
) (
    input  logic clk_in,
    input  logic reset,
    input  logic start_in,
    input  logic isStore_in,
    input  logic [2:0] funct3_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [XLEN-1:0] storeData_in,
    output logic busy_out,
    output logic done_out,
    output logic fault_out,
    output logic [XLEN-1:0] loadData_out,
    load_store_unit_if.master mem
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;
    state_t r_state;
    logic r_busy, r_done, r_fault, r_valid, r_we;
    logic [2:0] r_funct3;
    logic [OFFW-1:0] r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XLEN-1:0] r_wdata, r_load;
    logic [NBYTES-1:0] r_wstrb;
    logic [OFFW-1:0] w_lomask, w_off;
    logic [NBYTES-1:0] w_smask;
    logic w_illegal, w_fault, w_sbit;
    logic [XLEN-1:0] w_raw, w_ext;
    assign w_lomask = OFFW'((32'd1 << funct3_in[1:0]) - 32'd1);
    assign w_illegal = (isStore_in & funct3_in[2]) | (!isStore_in & (funct3_in == 3'b111))
                     | ((XLEN == 32) & ((funct3_in[1:0] == 2'b11) | (funct3_in == 3'b110)));
`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis = (addr_in[OFFW-1:0] & w_lomask) != '0;
    assign w_off = addr_in[OFFW-1:0];
    assign w_fault = w_illegal | w_mis;
`else
    assign w_off = addr_in[OFFW-1:0] & ~w_lomask;
    assign w_fault = w_illegal;
`endif
    always_comb begin
        w_smask = '0;
        for (int i = 0; i < NBYTES; i++) w_smask[i] = i < (1 << funct3_in[1:0]);
    end
    // Load extraction: shift the addressed lane down, then sign/zero-fill above the access size.
    assign w_raw = mem.memRspData_in >> {r_off, 3'b000};
    assign w_sbit = (r_funct3[1:0] == 2'd0) ? w_raw[7] :
                    (r_funct3[1:0] == 2'd1) ? w_raw[15] :
                    (r_funct3[1:0] == 2'd2) ? w_raw[31] : w_raw[XLEN-1];
    always_comb begin
        w_ext = '0;
        for (int i = 0; i < XLEN; i++)
            w_ext[i] = (i < (8 << r_funct3[1:0])) ? w_raw[i] : (w_sbit & ~r_funct3[2]);
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
            r_we <= 1'b0;
            r_funct3 <= '0;
            r_off <= '0;
            r_addr <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_load <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_in) begin
                    r_busy <= 1'b1;
                    if (w_fault) begin
                        r_state <= FAULT;
                        r_done <= 1'b1;
                        r_fault <= 1'b1;
                    end else begin
                        r_state <= REQ;
                        r_valid <= 1'b1;
                        r_funct3 <= funct3_in;
                        r_off <= w_off;
                        r_we <= isStore_in;
                        r_addr <= {addr_in[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        r_wdata <= storeData_in << {w_off, 3'b000};
                        r_wstrb <= isStore_in ? (w_smask << w_off) : '0;
                    end
                end
                REQ: if (mem.memReqReady_in) begin
                    r_state <= WAIT;
                    r_valid <= 1'b0;
                end
                WAIT: if (mem.memRspValid_in) begin
                    r_state <= DONE;
                    r_done <= 1'b1;
                    if (!r_we) r_load <= w_ext;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end
    assign busy_out = r_busy;
    assign done_out = r_done;
    assign fault_out = r_fault;
    assign loadData_out = r_load;
    assign mem.memReqValid_out = r_valid;
    assign mem.memWe_out = r_we;
    assign mem.memAddr_out = r_addr;
    assign mem.memWData_out = r_wdata;
    assign mem.memWStrb_out = r_wstrb;
endmodule
